latent_decoder_neuron: RTL and testbench
========================================

// Module: latent_decoder_neuron
// PURPOSE
// - Stage directly downstream of lambda_layer: consumes its sampled latent values (lambda_out) one per
//   handshake and computes one decoder neuron y = act(sum_i W[i]*z[i] + BIAS) in signed fixed point.
// - Serial MAC (one multiply per cycle) with valid/ready on both sides. Instances are replicated per
//   decoder output.
// PARAMETERS
// - N_IN    2         latent vector length, i.e. inputs accumulated per output (>=1)
// - DATA_W  16        width of z, W, BIAS and y; signed two's complement
// - FRAC_W  8         fractional bits of every operand and the result (Q8.8 at default)
// - WEIGHTS {N_IN{16'sh0100}}  packed weights, W[i] = WEIGHTS[i*DATA_W +: DATA_W]
// - BIAS    16'sh0000 bias, same Q format as the data
// - ACT     1         0 = identity, 1 = ReLU
// PORTS
// - clk        in   1       rising-edge clock
// - reset      in   1       synchronous, active-high
// - in_valid   in   1       in_data valid
// - in_ready   out  1       block accepts in_data this cycle
// - in_data    in   DATA_W  latent sample z[i], from lambda_out
// - out_valid  out  1       out_data valid; held until accepted
// - out_ready  in   1       downstream accepts out_data
// - out_data   out  DATA_W  neuron output y
// - busy       out  1       high whenever FSM is not IDLE
// BEHAVIOUR
// - Reset: FSM=IDLE, acc=0, idx=0, out_valid=0, out_data=0, busy=0, in_ready=1 on the next cycle.
// - FSM: IDLE -> ACCUM on first in_valid&in_ready; ACCUM -> BIAS when the N_IN-th sample is accepted;
//   BIAS -> OUT (one cycle); OUT -> IDLE when out_valid&out_ready. N_IN=1 goes IDLE -> BIAS directly.
// - in_ready = 1 in IDLE and ACCUM, 0 in BIAS and OUT. Transfer = in_valid & in_ready in the same cycle.
// - Per transfer: acc += z * W[idx] (full 2*DATA_W signed product); idx increments; at idx=N_IN-1,
//   idx wraps to 0. Sample order is index order; inputs received never skip or reorder.
// - Acc width = 2*DATA_W + clog2(N_IN) + 1 bits, no internal overflow possible.
// - BIAS state: acc += BIAS << FRAC_W; then result = acc >>> FRAC_W (arithmetic, floor rounding),
//   saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1], then ReLU if ACT=1 (negative -> 0).
// - Latency: last sample accepted in cycle t -> out_valid=1 in cycle t+2.
// - OUT: out_valid=1, out_data stable until out_ready. Handshake in cycle c -> out_valid=0, in_ready=1,
//   acc=0 in c+1. No new input accepted while OUT; result never overwritten or dropped.
// - in_valid idle gaps mid-vector: state and acc hold; no timeout.
// - Reset at any state mid-vector discards the partial sum; next accepted sample is index 0.
// - out_ready high before out_valid has no effect; X on in_data while in_valid=0 is ignored.
// STRUCTURE
// - Shared package: DATA_W/FRAC_W defaults, Q-format saturation limits, FSM state encoding
//   (IDLE/ACCUM/BIAS/OUT), sat_round helper function.
// - One natural sub-module: fxp_mac (registered multiply-accumulate with clear), instanced once.
// - FSM, index counter and output register remain in this module.
// TESTING  (defaults N_IN=2, FRAC_W=8, W0=0x0100 (1.0), W1=0x0080 (0.5), BIAS=0x0040 (0.25))
// - Basic: z=0x0200,0x0100 back-to-back, out_ready=1 -> out_data=0x02C0 (2.75) exactly 2 cycles after
//   the 2nd transfer, out_valid one cycle.
// - ReLU: z=0xFE00,0x0000, ACT=1 -> 0x0000; rebuilt with ACT=0 -> 0xFE40 (-1.75).
// - Saturation: z=0x7FFF,0x7FFF -> 0x7FFF; z=0x8000,0x8000 with ACT=0 -> 0x8000.
// - Backpressure: out_ready low 5 cycles after out_valid -> out_data held, in_ready=0, extra in_valid
//   pulses not consumed; out_ready=1 -> handshake, in_ready=1 next cycle, next vector correct.
// - Gaps: in_valid low 3 cycles between samples -> same 0x02C0 result, latency measured from 2nd transfer.
// - Reset mid-op: reset after first sample (0x0200) -> out_valid=0; then 0x0100,0x0200 -> 0x0240 (2.25).

Source files
------------

// File: rtl/latent_decoder_neuron_pkg.sv
// ---------------------------------------------------------------------------
// latent_decoder_neuron_pkg
// Shared definitions for the latent decoder neuron:
//   - default data / fraction widths and the matching Q-format saturation limits
//   - FSM state encoding (IDLE / ACCUM / BIAS / OUT)
//   - sat_round: arithmetic right shift (floor) followed by saturation
// ---------------------------------------------------------------------------
package latent_decoder_neuron_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int FRAC_W_DEF = 8;

    localparam logic signed [DATA_W_DEF-1:0] SAT_MAX_DEF = 16'sh7FFF;
    localparam logic signed [DATA_W_DEF-1:0] SAT_MIN_DEF = 16'sh8000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_BIAS  = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    // Drops frac_w fraction bits with floor rounding (arithmetic shift), then
    // clamps to the signed data_w range. The accumulator is handed in
    // sign-extended to 64 bits so the helper works for any data_w up to 31.
    function automatic logic signed [63:0] sat_round(
        input logic signed [63:0] acc,
        input int                 frac_w,
        input int                 data_w
    );
        logic signed [63:0] shifted;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        shifted = acc >>> frac_w;
        max_v   = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        min_v   = -(64'sd1 <<< (data_w - 1));
        if (shifted > max_v) begin
            return max_v;
        end else if (shifted < min_v) begin
            return min_v;
        end else begin
            return shifted;
        end
    endfunction

endpackage

// File: rtl/latent_decoder_neuron_fxp_mac.sv
// ---------------------------------------------------------------------------
// latent_decoder_neuron_fxp_mac
// Registered signed multiply-accumulate with synchronous clear.
// Ports:
//   clk       rising-edge clock
//   reset     synchronous active-high reset, clears the accumulator
//   clr       clear accumulator on the next edge (has priority over en)
//   en        accumulate a*b on the next edge
//   a, b      signed DATA_W operands
//   acc_next  combinational acc + a*b (lets the owner see the post-add value)
//   acc       registered accumulator
// ---------------------------------------------------------------------------
module latent_decoder_neuron_fxp_mac #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 33
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [ACC_W-1:0]  acc_next,
    output logic signed [ACC_W-1:0]  acc
);

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    acc_q;
    logic signed [ACC_W-1:0]    acc_d;

    always_comb begin
        prod     = a * b;
        acc_next = acc_q + ACC_W'(prod);
        acc_d    = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/latent_decoder_neuron.sv
// ---------------------------------------------------------------------------
// latent_decoder_neuron
// One decoder neuron y = act(sum_i W[i]*z[i] + BIAS), signed fixed point,
// computed with a serial MAC (one sample per accepted handshake).
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   in_valid   in_data valid
//   in_ready   sample accepted this cycle when in_valid is also high
//   in_data    latent sample z[i], delivered in index order
//   out_valid  out_data valid, held until out_ready
//   out_ready  downstream accepts out_data
//   out_data   neuron output y
//   busy       high whenever the FSM is not idle
// FRAC_W must be at most DATA_W-2: the bias is scaled by multiplying it with
// 1.0 in the Q format, which has to be representable as a positive DATA_W value.
// ---------------------------------------------------------------------------
module latent_decoder_neuron
    import latent_decoder_neuron_pkg::*;
#(
    parameter int                       N_IN    = 2,
    parameter int                       DATA_W  = DATA_W_DEF,
    parameter int                       FRAC_W  = FRAC_W_DEF,
    parameter logic [N_IN*DATA_W-1:0]   WEIGHTS = {N_IN{16'sh0100}},
    parameter logic signed [DATA_W-1:0] BIAS    = 16'sh0000,
    parameter int                       ACT     = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
);

    localparam int ACC_W = 2*DATA_W + $clog2(N_IN) + 1;
    localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic signed [DATA_W-1:0] ONE_Q = DATA_W'(1) << FRAC_W;

    // Unpack the weight vector into an indexable table.
    logic signed [DATA_W-1:0] w_arr [0:N_IN-1];

    genvar gi;
    generate
        for (gi = 0; gi < N_IN; gi++) begin : g_w
            assign w_arr[gi] = WEIGHTS[gi*DATA_W +: DATA_W];
        end
    endgenerate

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic               busy_q, busy_d;

    logic                     mac_clr;
    logic                     mac_en;
    logic signed [DATA_W-1:0] mac_a;
    logic signed [DATA_W-1:0] mac_b;
    logic signed [ACC_W-1:0]  acc_next;
    logic signed [ACC_W-1:0]  acc;

    logic                     transfer;
    logic                     last_idx;
    logic signed [DATA_W-1:0] sat_res;

    latent_decoder_neuron_fxp_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk      (clk),
        .reset    (reset),
        .clr      (mac_clr),
        .en       (mac_en),
        .a        (mac_a),
        .b        (mac_b),
        .acc_next (acc_next),
        .acc      (acc)
    );

    assign transfer = in_valid & in_ready_q;
    assign last_idx = (idx_q == IDX_W'(N_IN - 1));

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        mac_clr     = 1'b0;
        mac_en      = 1'b0;
        mac_a       = '0;
        mac_b       = '0;
        sat_res     = DATA_W'(sat_round(64'(acc_next), FRAC_W, DATA_W));

        case (state_q)
            ST_IDLE, ST_ACCUM: begin
                if (transfer) begin
                    mac_en = 1'b1;
                    mac_a  = in_data;
                    mac_b  = w_arr[idx_q];
                    if (last_idx) begin
                        idx_d   = '0;
                        state_d = ST_BIAS;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_ACCUM;
                    end
                end
            end
            ST_BIAS: begin
                // BIAS * 1.0 == BIAS << FRAC_W, reusing the multiplier path.
                // The post-add value is rounded straight into the output
                // register so out_valid rises two cycles after the last sample.
                mac_en      = 1'b1;
                mac_a       = BIAS;
                mac_b       = ONE_Q;
                out_valid_d = 1'b1;
                if ((ACT == 1) && sat_res[DATA_W-1]) begin
                    out_data_d = '0;
                end else begin
                    out_data_d = sat_res;
                end
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    mac_clr     = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d = (state_d == ST_IDLE) || (state_d == ST_ACCUM);
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_latent_decoder_neuron.sv
// Directed bench: two instances share the input side, one with ReLU (ACT=1)
// and one with identity (ACT=0). W0=1.0, W1=0.5, BIAS=0.25, Q8.8.
module tb_latent_decoder_neuron;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;

    logic        in_ready_r, out_valid_r, busy_r;
    logic [15:0] out_data_r;
    logic        in_ready_l, out_valid_l, busy_l;
    logic [15:0] out_data_l;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    latent_decoder_neuron #(
        .N_IN    (2),
        .DATA_W  (16),
        .FRAC_W  (8),
        .WEIGHTS ({16'h0080, 16'h0100}),
        .BIAS    (16'sh0040),
        .ACT     (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready_r),
        .in_data   (in_data),
        .out_valid (out_valid_r),
        .out_ready (out_ready),
        .out_data  (out_data_r),
        .busy      (busy_r)
    );

    latent_decoder_neuron #(
        .N_IN    (2),
        .DATA_W  (16),
        .FRAC_W  (8),
        .WEIGHTS ({16'h0080, 16'h0100}),
        .BIAS    (16'sh0040),
        .ACT     (0)
    ) dut_lin (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready_l),
        .in_data   (in_data),
        .out_valid (out_valid_l),
        .out_ready (out_ready),
        .out_data  (out_data_l),
        .busy      (busy_l)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present z until accepted; returns #1 after the accepting edge.
    task automatic send(input logic [15:0] z);
        int waited;
        waited = 0;
        in_valid = 1'b1;
        in_data  = z;
        while (!in_ready_r && waited < 20) begin
            tick();
            waited++;
        end
        if (!in_ready_r) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: observed in_ready=0 expected 1 within 20 cycles");
        end
        tick();
        in_valid = 1'b0;
        in_data  = 16'hxxxx;
    endtask

    // Checks two-cycle latency after the last sample and both results,
    // then completes the handshake with out_ready=1.
    task automatic expect_result(input string tag, input logic [15:0] exp_r, input logic [15:0] exp_l);
        chk({tag, "_lat_valid0"}, {15'd0, out_valid_r}, 16'd0);
        tick();
        chk({tag, "_valid"}, {15'd0, out_valid_r}, 16'd1);
        chk({tag, "_relu"}, out_data_r, exp_r);
        chk({tag, "_lin"}, out_data_l, exp_l);
        $display("txn %s: relu=%h lin=%h", tag, out_data_r, out_data_l);
        tick();
        chk({tag, "_valid_drop"}, {15'd0, out_valid_r}, 16'd0);
        chk({tag, "_in_ready"}, {15'd0, in_ready_r}, 16'd1);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_out_valid", {15'd0, out_valid_r}, 16'd0);
        chk("rst_out_data", out_data_r, 16'h0000);
        chk("rst_busy", {15'd0, busy_r}, 16'd0);
        chk("rst_in_ready", {15'd0, in_ready_r}, 16'd1);

        // Basic: 2.0*1.0 + 1.0*0.5 + 0.25 = 2.75
        send(16'h0200);
        chk("basic_busy", {15'd0, busy_r}, 16'd1);
        send(16'h0100);
        chk("basic_in_ready_bias", {15'd0, in_ready_r}, 16'd0);
        expect_result("basic", 16'h02C0, 16'h02C0);

        // ReLU: -2.0 + 0 + 0.25 = -1.75
        send(16'hFE00);
        send(16'h0000);
        expect_result("relu", 16'h0000, 16'hFE40);

        // Positive saturation
        send(16'h7FFF);
        send(16'h7FFF);
        expect_result("sat_pos", 16'h7FFF, 16'h7FFF);

        // Negative saturation: -128 - 64 + 0.25 -> clamp
        send(16'h8000);
        send(16'h8000);
        expect_result("sat_neg", 16'h0000, 16'h8000);

        // Backpressure
        out_ready = 1'b0;
        send(16'h0200);
        send(16'h0100);
        tick();
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            in_data  = 16'h1234;
            chk("bp_valid", {15'd0, out_valid_r}, 16'd1);
            chk("bp_data", out_data_r, 16'h02C0);
            chk("bp_in_ready", {15'd0, in_ready_r}, 16'd0);
            tick();
        end
        in_valid  = 1'b1;
        out_ready = 1'b1;
        chk("bp_hold_last", out_data_r, 16'h02C0);
        tick();
        in_valid = 1'b0;
        chk("bp_released", {15'd0, out_valid_r}, 16'd0);
        chk("bp_in_ready_after", {15'd0, in_ready_r}, 16'd1);
        chk("bp_busy_after", {15'd0, busy_r}, 16'd0);
        $display("txn backpressure: released after 5 held cycles");
        send(16'h0100);
        send(16'h0200);
        expect_result("bp_next", 16'h0240, 16'h0240);

        // Gaps between samples
        send(16'h0200);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("gap_hold_busy", {15'd0, busy_r}, 16'd1);
            chk("gap_no_out", {15'd0, out_valid_r}, 16'd0);
        end
        send(16'h0100);
        expect_result("gaps", 16'h02C0, 16'h02C0);

        // Reset mid-vector discards the partial sum
        send(16'h0200);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_out_valid", {15'd0, out_valid_r}, 16'd0);
        chk("midrst_busy", {15'd0, busy_r}, 16'd0);
        chk("midrst_in_ready", {15'd0, in_ready_r}, 16'd1);
        send(16'h0100);
        send(16'h0200);
        expect_result("midrst", 16'h0240, 16'h0240);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
